// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer: one input stream steered into four one-deep lane registers,
// addressed by an explicit select or by a round-robin pointer that advances on each accept.
module demux4_reg #(
  parameter int unsigned bits = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [bits-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      select,
  input  logic            rr_mode,
  output logic [bits-1:0] out_A,
  output logic [bits-1:0] out_B,
  output logic [bits-1:0] out_C,
  output logic [bits-1:0] out_D,
  output logic [3:0]      valid_out,
  input  logic [3:0]      ready_out,
  output logic [1:0]      ptr
);

  logic [bits-1:0] lane_q [4];
  logic [bits-1:0] lane_d [4];
  logic [3:0]      valid_q, valid_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      tgt;
  logic            accept;

  assign tgt      = rr_mode ? ptr_q : select;
  // A full lane can be refilled in the same cycle its consumer drains it.
  assign in_ready = ~valid_q[tgt] | ready_out[tgt];
  assign accept   = in_valid & in_ready;

  always_comb begin
    lane_d  = lane_q;
    valid_d = valid_q & ~ready_out;
    ptr_d   = ptr_q;
    if (accept) begin
      lane_d[tgt]  = in_data;
      valid_d[tgt] = 1'b1;
      if (rr_mode) begin
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      valid_q <= 4'b0000;
      ptr_q   <= 2'd0;
    end else begin
      lane_q  <= lane_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_A     = lane_q[0];
  assign out_B     = lane_q[1];
  assign out_C     = lane_q[2];
  assign out_D     = lane_q[3];
  assign valid_out = valid_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Directed bench for demux4_reg: a reference model predicts lane state each cycle and a
// scoreboard queue holds accepted words until the DUT drains them on their lane.
module tb_demux4_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] select;
  logic       rr_mode;
  logic [2:0] out_A, out_B, out_C, out_D;
  logic [3:0] valid_out;
  logic [3:0] ready_out;
  logic [1:0] ptr;

  always #5 clock = ~clock;

  demux4_reg #(.bits(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .select   (select),
    .rr_mode  (rr_mode),
    .out_A    (out_A),
    .out_B    (out_B),
    .out_C    (out_C),
    .out_D    (out_D),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .ptr      (ptr)
  );

  typedef struct {
    logic [1:0] lane;
    logic [2:0] data;
  } sb_t;

  sb_t        sbq [$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] m_lane [4];
  logic [3:0] m_valid;
  logic [1:0] m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] dut_lane(input int i);
    case (i)
      0:       return out_A;
      1:       return out_B;
      2:       return out_C;
      default: return out_D;
    endcase
  endfunction

  // One clock: check in_ready before the edge, update model/scoreboard, check state after it.
  task automatic tick();
    logic [1:0] t;
    logic       rdy;
    logic       acc;
    logic [3:0] nv;
    int         idx;
    #1;
    t   = rr_mode ? m_ptr : select;
    rdy = ~m_valid[t] | ready_out[t];
    acc = in_valid & rdy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_lane[i] = 3'd0;
      m_valid = 4'b0000;
      m_ptr   = 2'd0;
      sbq.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i] && ready_out[i]) begin
          idx = -1;
          foreach (sbq[k]) if (idx < 0 && sbq[k].lane == 2'(i)) idx = k;
          chk("sb_has_word", {31'd0, idx >= 0}, 32'd1);
          if (idx >= 0) begin
            chk($sformatf("drain_lane%0d", i), {29'd0, dut_lane(i)}, {29'd0, sbq[idx].data});
            sbq.delete(idx);
          end
        end
      end
      nv = m_valid & ~ready_out;
      if (acc) begin
        m_lane[t] = in_data;
        nv[t]     = 1'b1;
        sbq.push_back('{lane: t, data: in_data});
        if (rr_mode) m_ptr = m_ptr + 2'd1;
      end
      m_valid = nv;
    end
    @(posedge clock);
    #1;
    chk("valid_out", {28'd0, valid_out}, {28'd0, m_valid});
    chk("ptr", {30'd0, ptr}, {30'd0, m_ptr});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lane%0d", i), {29'd0, dut_lane(i)}, {29'd0, m_lane[i]});
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_lane[i] = 3'bx;
    m_valid   = 4'bx;
    m_ptr     = 2'bx;
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 3'd7;
    select    = 2'd0;
    rr_mode   = 1'b0;
    ready_out = 4'b0000;
    @(posedge clock);
    #1;

    // Reset with an offered word, then first accept into C.
    tick();
    tick();
    chk("reset_valid", {28'd0, valid_out}, 32'h0);
    chk("reset_ptr", {30'd0, ptr}, 32'h0);
    reset   = 1'b1;
    select  = 2'd2;
    in_data = 3'd5;
    tick();
    chk("first_C", {29'd0, out_C}, 32'd5);
    chk("first_valid", {28'd0, valid_out}, 32'b0100);
    in_valid  = 1'b0;
    ready_out = 4'b0100;
    tick();

    // Addressed backpressure on B, then simultaneous drain and refill.
    ready_out = 4'b0000;
    in_valid  = 1'b1;
    select    = 2'd1;
    in_data   = 3'd3;
    tick();
    chk("bp_valid", {28'd0, valid_out}, 32'b0010);
    in_data = 3'd4;
    #1;
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("bp_hold_B", {29'd0, out_B}, 32'd3);
    ready_out = 4'b0010;
    in_data   = 3'd6;
    tick();
    chk("refill_B", {29'd0, out_B}, 32'd6);
    chk("refill_valid", {31'd0, valid_out[1]}, 32'd1);
    in_valid = 1'b0;
    tick();

    // Round-robin wrap with all consumers ready.
    rr_mode   = 1'b1;
    ready_out = 4'b1111;
    in_valid  = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      in_data = 3'(w);
      tick();
      chk("rr_ptr", {30'd0, ptr}, 32'(w % 4));
    end
    chk("rr_wrap_A", {29'd0, out_A}, 32'd5);
    chk("rr_D", {29'd0, out_D}, 32'd4);
    in_valid = 1'b0;
    tick();

    // Round-robin stall: ptr=2 with C full and its consumer stalled.
    ready_out = 4'b0000;
    rr_mode   = 1'b0;
    select    = 2'd2;
    in_valid  = 1'b1;
    in_data   = 3'd2;
    tick();
    rr_mode = 1'b1;
    in_data = 3'd1;
    tick();
    chk("stall_ptr_start", {30'd0, ptr}, 32'd2);
    in_data = 3'd3;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_ptr_hold", {30'd0, ptr}, 32'd2);
    end
    ready_out = 4'b0100;
    tick();
    chk("stall_release_C", {29'd0, out_C}, 32'd3);
    chk("stall_release_ptr", {30'd0, ptr}, 32'd3);

    // Parallel drain of A and D during an accept into B.
    in_valid  = 1'b0;
    ready_out = 4'b1111;
    tick();
    ready_out = 4'b0000;
    rr_mode   = 1'b0;
    in_valid  = 1'b1;
    select    = 2'd0;
    in_data   = 3'd4;
    tick();
    select  = 2'd3;
    in_data = 3'd6;
    tick();
    select    = 2'd1;
    in_data   = 3'd2;
    ready_out = 4'b1001;
    tick();
    chk("par_valid", {28'd0, valid_out}, 32'b0010);
    chk("par_A", {29'd0, out_A}, 32'd4);
    chk("par_D", {29'd0, out_D}, 32'd6);

    // Reset mid-operation with all lanes full and ptr=3.
    ready_out = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      if (l != 1) begin
        select  = 2'(l);
        in_data = 3'(l + 1);
        tick();
      end
    end
    chk("mid_full", {28'd0, valid_out}, 32'b1111);
    chk("mid_ptr", {30'd0, ptr}, 32'd3);
    reset   = 1'b0;
    in_data = 3'd7;
    tick();
    chk("mid_reset_valid", {28'd0, valid_out}, 32'h0);
    chk("mid_reset_ptr", {30'd0, ptr}, 32'h0);
    chk("mid_reset_A", {29'd0, out_A}, 32'h0);
    reset = 1'b1;
    #1;
    chk("post_reset_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux4_reg.md
# demux4_reg

Registered 1-to-4 demultiplexer with per-lane valid/ready handshakes. It is the distributing counterpart to the registered 4-to-1 mux slice: one `bits`-wide input stream is steered into one of four output lanes A–D. Each lane has a one-deep holding register. The target lane comes from an explicit 2-bit select or from an internal round-robin pointer. The block sits between a single producer and four consumers in the datapath.

## Interface
- `bits`, default 3: data width of the input and of each lane.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous reset, active-low. Sampled on the rising edge of `clock`; 0 resets.
- `in_data` in `bits`: input word.
- `in_valid` in 1: producer offers `in_data`.
- `in_ready` out 1: block can accept the word this cycle. Combinational.
- `select` in 2: target lane when `rr_mode`=0 (0=A, 1=B, 2=C, 3=D).
- `rr_mode` in 1: 1 = target lane is the internal pointer `ptr`; `select` is ignored.
- `out_A`, `out_B`, `out_C`, `out_D` out `bits` each: lane holding registers.
- `valid_out` out 4: bit i = lane i holds a word (bit 0 = A … bit 3 = D).
- `ready_out` in 4: bit i = consumer i takes the word this cycle.
- `ptr` out 2: round-robin pointer, registered.

## Operation
- Target lane: `t = rr_mode ? ptr : select`.
- Per-lane state: data register `out_X` and full flag `valid_out[i]`.
- Ready rule: `in_ready = !valid_out[t] | ready_out[t]`. This allows a full lane to be refilled in the same cycle it drains.
- Accept: `in_valid & in_ready`.
  - On the next edge, `out_[t] <= in_data` and `valid_out[t] <= 1`.
- Drain: `valid_out[i] & ready_out[i]`.
  - On the next edge, `valid_out[i] <= 0`, unless lane i is also accepting that cycle.
  - On simultaneous accept and drain of the same lane, `valid_out[i]` stays 1 and the data is replaced by the new word.
- Drains on non-target lanes proceed independently and in parallel with an accept on the target lane.
- Lane data is held stable while `valid_out[i]`=1 and `ready_out[i]`=0.
  - Data registers update only on accept.
  - After a drain, the data register keeps its last value; it is not cleared.
- Pointer:
  - In `rr_mode`=1, `ptr` increments on every accept and wraps 3→0.
  - `ptr` does not advance without an accept, e.g. while the target lane is full and its consumer is stalled. Lane order is strict; full lanes are not skipped.
  - In `rr_mode`=0, `ptr` holds its value. Toggling `rr_mode` never modifies `ptr`.
- `select`/`rr_mode` changes with `in_valid`=1 are legal. The target is re-evaluated every cycle with no stickiness.
- Reset (`reset`=0 at an edge) takes priority over all other activity, including an accept or drain in the same cycle:
  - `out_A`..`out_D` = 0, `valid_out` = 4'b0000, `ptr` = 0.
  - `in_ready` then follows the ready rule from the cleared state, i.e. 1.
- Widths: no arithmetic on data. `ptr` is a 2-bit modulo-4 counter.

## Timing
- Latency: a word accepted at edge N is visible on `out_[t]` with `valid_out[t]`=1 after edge N, i.e. one cycle.
- Throughput: one word per cycle. This holds in round-robin mode and on a single lane whose consumer holds `ready_out` high.
- Combinational paths: `ready_out`, `select`, `rr_mode` → `in_ready`. No combinational path from `in_data` or `in_valid` to any output.
- All outputs except `in_ready` are registered.
- Out of reset, an accept is possible in the first cycle after `reset` returns high.

## Test plan
- **Reset and first accept.** Assert `reset`=0 for 2 cycles with `in_valid`=1 → `valid_out`=0000, `ptr`=0, all lanes 0. Release reset, drive `select`=2, `in_data`=5 → next cycle `out_C`=5, `valid_out`=0100.
- **Addressed backpressure.** `bits`=3, `ready_out`=0000. Send 3 to lane B → `valid_out`=0010. Hold `select`=1 → `in_ready`=0, `out_B` stays 3. Raise `ready_out[1]` with `in_data`=6 → same edge drains and refills, `out_B`=6, `valid_out[1]` stays 1.
- **Round-robin wrap.** `rr_mode`=1, `ready_out`=1111, stream 1,2,3,4,5 → lanes A,B,C,D,A receive them in order. `ptr` sequence is 0,1,2,3,0,1, with one accept per cycle.
- **Round-robin stall.** `rr_mode`=1, `ptr`=2, lane C full, `ready_out[2]`=0 → `in_ready`=0 and `ptr` stays 2 for as long as the stall lasts. Raise `ready_out[2]` → accept into C, then `ptr`=3.
- **Parallel drain.** Lanes A and D full. Accept into B while `ready_out`=1001 → next cycle `valid_out`=0010, and the data on A and D is unchanged.
- **Reset mid-operation.** With all lanes full and `ptr`=3, assert `reset`=0 for one cycle while `in_valid`=1 → `valid_out`=0000, `ptr`=0, lanes 0. No word is captured that cycle.
